phase_ctrl: RTL and testbench
=============================

# phase_ctrl

Instruction-phase controller for the P12 CPU core. It produces the four phase strobes (fetch, execute, memory, writeback) that step the datapath. It stretches the fetch and memory phases until the memory bus acknowledges, and it adds run/halt/single-step control and cycle/instruction counters for the test monitor. It replaces the fixed-rate phase scheduler in front of the CPU datapath; the datapath consumes phf/phe/phm/phw unchanged.

## Interface
- RUN_ON_RESET, 1, 1: enter FETCH after reset; 0: enter HALT
- WAIT_MAX, 15, maximum wait cycles per bus access before forced completion (1..255)
- CNT_WIDTH, 32, width of cycle and instruction counters
- clk  input  1  system clock
- reset  input  1  **one clock; reset is synchronous and active-high**
- run  input  1  level; 1 allows free-running execution
- halt_req  input  1  level; stop at the next instruction boundary
- step  input  1  single-step request; rising edge is detected internally
- inst_ld  input  1  decoded LD of the current IC
- inst_st  input  1  decoded ST of the current IC
- mem_ready  input  1  bus acknowledge for the current access
- err_clr  input  1  clears bus_err
- phf, phe, phm, phw  output  1 each  phase strobes, each at most one cycle per instruction
- mem_req  output  1  bus access active
- mem_wen  output  1  write strobe (ST in MEM)
- halted  output  1  controller is in HALT
- bus_err  output  1  sticky; a bus access timed out
- clk_stat  output  3  current state code, for the test mux
- cyc_cnt  output  CNT_WIDTH  cycles spent outside HALT
- ins_cnt  output  CNT_WIDTH  completed instructions

## Operation
- States and codes: HALT=0, FETCH=1, EXEC=2, MEM=3, WB=4.
- FETCH
  - mem_req=1.
  - While mem_ready=0: stay and increment wait_cnt.
  - On mem_ready=1: phf=1, go to EXEC.
- EXEC: phe=1 for one cycle, go to MEM.
- MEM with a bus access (inst_ld|inst_st)
  - mem_req=1, mem_wen=inst_st.
  - Wait for mem_ready as in FETCH.
  - On completion: phm=1, go to WB.
- MEM without a bus access: phm=1 for one cycle, mem_req=0, go to WB.
- WB
  - phw=1, ins_cnt increments.
  - Next state:
    - HALT if halt_req=1, or run=0, or the current instruction was started by a step.
    - FETCH otherwise.
- HALT
  - All strobes and mem_req are 0.
  - Go to FETCH when run=1 and halt_req=0, or when a step edge is pending.
  - A step edge in HALT executes exactly one instruction, even if halt_req=1.
- Step edges outside HALT are ignored, not queued.
- Timeout
  - wait_cnt is cleared on entry to FETCH and to MEM.
  - If wait_cnt reaches WAIT_MAX with mem_ready still 0, the phase completes as if acknowledged (strobe issued) and bus_err is set.
- bus_err
  - Cleared by reset or err_clr.
  - If a set and err_clr happen in the same cycle, set wins.
- cyc_cnt increments in every cycle whose state is not HALT.
- Both counters wrap modulo 2^CNT_WIDTH.
- halt_req arriving mid-instruction never truncates it: the current instruction always runs to the end of WB.

## Timing
- Reset values
  - State: FETCH if RUN_ON_RESET=1, else HALT.
  - All strobes, mem_req, mem_wen, bus_err: 0.
  - Counters: 0.
  - halted = !RUN_ON_RESET.
- All outputs decode combinationally from the registered state and inputs. phf and phm are functions of mem_ready in the same cycle.
- Zero-wait instruction: 4 cycles (FETCH, EXEC, MEM, WB). Each wait cycle adds 1.
- A reset asserted in any cycle takes effect at that clock edge: the next cycle is the reset state with all strobes 0. Any pending step edge and wait_cnt are cleared.
- Step edge detection
  - Uses a registered copy of step; the register resets to 1, so a level held high through reset is not an edge.
  - An edge seen in HALT moves to FETCH on the next cycle.
- mem_ready outside FETCH and MEM is ignored.

## Structure
- Shared include file p12_defs: the state codes and the clk_stat encoding, shared with the test monitor.
- One sub-module, edge_det: registered rising-edge detector for step, with reset value 1.
- The remainder is a single FSM, wait counter, two performance counters and the sticky error flag, all in phase_ctrl.

## Test plan
- Basic run: RUN_ON_RESET=1, mem_ready=1, inst_ld=inst_st=0, 3 instructions → strobe sequence phf, phe, phm, phw repeats every 4 cycles; ins_cnt=3, cyc_cnt=12, mem_req high only in FETCH.
- LD with waits: 2 wait cycles on fetch, 3 on MEM → instruction takes 9 cycles; phf on cycle 3, phm on cycle 8; mem_wen=0 throughout.
- Timeout: WAIT_MAX=4, mem_ready=0 during an ST in MEM → phm issued on the 5th MEM cycle, mem_wen=1 in each of those cycles, bus_err=1 and stays set; err_clr pulse → 0.
- Halt/step: halt_req raised during EXEC → that instruction finishes WB, then halted=1. Step pulse → exactly one 4-cycle instruction, ins_cnt+1, back to HALT. Step held high produces no second instruction.
- Reset mid-MEM: reset in a MEM wait cycle with RUN_ON_RESET=0 → next cycle halted=1, all strobes 0, counters 0, bus_err 0.
- Counter wrap: CNT_WIDTH=4, run 17 zero-wait instructions → ins_cnt=1, cyc_cnt=4.

Source files
------------

// File: rtl/phase_ctrl_pkg.sv
// Shared P12 phase-controller definitions: state codes and the clk_stat
// encoding, used by phase_ctrl and by the test monitor that decodes clk_stat.
package phase_ctrl_pkg;

    // Width of the state code, which is also the width of clk_stat.
    localparam int STATE_W = 3;

    // Width of the per-access wait counter. WAIT_MAX is limited to 1..255.
    localparam int WAIT_W = 8;

    // Controller states. The numeric codes are visible on clk_stat and must
    // stay stable because the test monitor decodes them.
    typedef enum logic [STATE_W-1:0] {
        ST_HALT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4
    } state_e;

    // clk_stat encoding: the raw state code.
    function automatic logic [STATE_W-1:0] stat_code(input state_e s);
        logic [STATE_W-1:0] code;
        code = s;
        return code;
    endfunction

endpackage

// File: rtl/phase_ctrl_edge_det.sv
// Rising-edge detector for the single-step input. The registered copy resets
// to 1, so a level that is already high while reset is released does not
// count as an edge.
module phase_ctrl_edge_det (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    // Track the previous sample of the input; reset high to mask held levels.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/phase_ctrl.sv
// P12 instruction-phase controller. Sequences FETCH/EXEC/MEM/WB, stretches
// FETCH and bus MEM phases until the bus acknowledges (or a wait limit is
// hit), and provides run/halt/single-step control plus cycle and
// instruction counters for the test monitor.
module phase_ctrl
    import phase_ctrl_pkg::*;
#(
    parameter int RUN_ON_RESET = 1,
    parameter int WAIT_MAX     = 15,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_run,
    input  logic                 i_halt_req,
    input  logic                 i_step,
    input  logic                 i_inst_ld,
    input  logic                 i_inst_st,
    input  logic                 i_mem_ready,
    input  logic                 i_err_clr,
    output logic                 o_phf,
    output logic                 o_phe,
    output logic                 o_phm,
    output logic                 o_phw,
    output logic                 o_mem_req,
    output logic                 o_mem_wen,
    output logic                 o_halted,
    output logic                 o_bus_err,
    output logic [STATE_W-1:0]   o_clk_stat,
    output logic [CNT_WIDTH-1:0] o_cyc_cnt,
    output logic [CNT_WIDTH-1:0] o_ins_cnt
);

    localparam state_e             L_RESET_STATE = (RUN_ON_RESET != 0) ? ST_FETCH : ST_HALT;
    localparam logic [WAIT_W-1:0]  L_WAIT_MAX    = WAIT_W'(WAIT_MAX);
    localparam logic [WAIT_W-1:0]  L_WAIT_ONE    = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] L_CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Registered state
    state_e                 r_state;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic                   r_step_inst;   // current instruction was launched by a step
    logic                   r_bus_err;
    logic [CNT_WIDTH-1:0]   r_cyc_cnt;
    logic [CNT_WIDTH-1:0]   r_ins_cnt;

    // Combinational helpers
    logic w_step_edge;
    logic w_bus_access;
    logic w_wait_full;
    logic w_fetch_done;
    logic w_mem_done;
    logic w_timeout;
    logic w_wb_to_halt;
    logic w_halt_leave;

    phase_ctrl_edge_det u_step_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_sig   (i_step),
        .o_rise  (w_step_edge)
    );

    // Phase completion and timeout decode from the registered state.
    always_comb begin
        w_bus_access = i_inst_ld | i_inst_st;
        w_wait_full  = (r_wait_cnt == L_WAIT_MAX);
        w_fetch_done = 1'b0;
        w_mem_done   = 1'b0;
        w_timeout    = 1'b0;
        if (r_state == ST_FETCH) begin
            // A full wait counter forces completion even without an acknowledge.
            w_fetch_done = i_mem_ready | w_wait_full;
            w_timeout    = ~i_mem_ready & w_wait_full;
        end else if (r_state == ST_MEM) begin
            if (w_bus_access) begin
                w_mem_done = i_mem_ready | w_wait_full;
                w_timeout  = ~i_mem_ready & w_wait_full;
            end else begin
                // No bus access: MEM is a single cycle, mem_ready is ignored.
                w_mem_done = 1'b1;
                w_timeout  = 1'b0;
            end
        end else begin
            w_fetch_done = 1'b0;
            w_mem_done   = 1'b0;
            w_timeout    = 1'b0;
        end
    end

    // Instruction-boundary decisions for WB and HALT.
    always_comb begin
        w_wb_to_halt = i_halt_req | ~i_run | r_step_inst;
        w_halt_leave = w_step_edge | (i_run & ~i_halt_req);
    end

    // Phase sequencer with its wait counter and step-origin flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= L_RESET_STATE;
            r_wait_cnt  <= {WAIT_W{1'b0}};
            r_step_inst <= 1'b0;
        end else begin
            case (r_state)
                ST_HALT: begin
                    if (w_halt_leave) begin
                        r_state     <= ST_FETCH;
                        r_wait_cnt  <= {WAIT_W{1'b0}};
                        // A step edge wins over halt_req and limits the run to one instruction.
                        r_step_inst <= w_step_edge;
                    end else begin
                        r_state     <= ST_HALT;
                        r_wait_cnt  <= {WAIT_W{1'b0}};
                        r_step_inst <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (w_fetch_done) begin
                        r_state    <= ST_EXEC;
                        r_wait_cnt <= {WAIT_W{1'b0}};
                    end else begin
                        r_state    <= ST_FETCH;
                        r_wait_cnt <= r_wait_cnt + L_WAIT_ONE;
                    end
                end
                ST_EXEC: begin
                    // Entering MEM starts a fresh wait budget.
                    r_state    <= ST_MEM;
                    r_wait_cnt <= {WAIT_W{1'b0}};
                end
                ST_MEM: begin
                    if (w_mem_done) begin
                        r_state    <= ST_WB;
                        r_wait_cnt <= {WAIT_W{1'b0}};
                    end else begin
                        r_state    <= ST_MEM;
                        r_wait_cnt <= r_wait_cnt + L_WAIT_ONE;
                    end
                end
                ST_WB: begin
                    r_wait_cnt <= {WAIT_W{1'b0}};
                    if (w_wb_to_halt) begin
                        r_state     <= ST_HALT;
                        r_step_inst <= 1'b0;
                    end else begin
                        r_state     <= ST_FETCH;
                        r_step_inst <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable codes recover to a quiet, safe state.
                    r_state     <= ST_HALT;
                    r_wait_cnt  <= {WAIT_W{1'b0}};
                    r_step_inst <= 1'b0;
                end
            endcase
        end
    end

    // Sticky bus-timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
        end else if (i_err_clr) begin
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= r_bus_err;
        end
    end

    // Cycle counter: every non-HALT cycle, wrapping naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cyc_cnt <= {CNT_WIDTH{1'b0}};
        end else if (r_state != ST_HALT) begin
            r_cyc_cnt <= r_cyc_cnt + L_CNT_ONE;
        end else begin
            r_cyc_cnt <= r_cyc_cnt;
        end
    end

    // Instruction counter: one count per WB cycle, wrapping naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ins_cnt <= {CNT_WIDTH{1'b0}};
        end else if (r_state == ST_WB) begin
            r_ins_cnt <= r_ins_cnt + L_CNT_ONE;
        end else begin
            r_ins_cnt <= r_ins_cnt;
        end
    end

    // Output decode from the registered state and same-cycle inputs; the
    // datapath needs phf/phm in the cycle the bus acknowledges.
    always_comb begin
        o_phf     = 1'b0;
        o_phe     = 1'b0;
        o_phm     = 1'b0;
        o_phw     = 1'b0;
        o_mem_req = 1'b0;
        o_mem_wen = 1'b0;
        case (r_state)
            ST_FETCH: begin
                o_mem_req = 1'b1;
                o_phf     = w_fetch_done;
            end
            ST_EXEC: begin
                o_phe = 1'b1;
            end
            ST_MEM: begin
                o_mem_req = w_bus_access;
                o_mem_wen = i_inst_st;
                o_phm     = w_mem_done;
            end
            ST_WB: begin
                o_phw = 1'b1;
            end
            default: begin
                o_phf     = 1'b0;
                o_phe     = 1'b0;
                o_phm     = 1'b0;
                o_phw     = 1'b0;
                o_mem_req = 1'b0;
                o_mem_wen = 1'b0;
            end
        endcase
    end

    assign o_halted   = (r_state == ST_HALT);
    assign o_bus_err  = r_bus_err;
    assign o_clk_stat = stat_code(r_state);
    assign o_cyc_cnt  = r_cyc_cnt;
    assign o_ins_cnt  = r_ins_cnt;

endmodule

// File: tb/tb_phase_ctrl.sv
// Self-checking bench for phase_ctrl. Instance A (run on reset, WAIT_MAX=4)
// is driven from a per-cycle vector table; instance B (halt on reset,
// 4-bit counters) is exercised by hand-written counter-wrap and reset
// sequences.
module tb_phase_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- instance A ----------------
    logic rst_a, run_a, hreq_a, step_a, ld_a, st_a, rdy_a, clr_a;
    logic phf_a, phe_a, phm_a, phw_a, req_a, wen_a, hlt_a, err_a;
    logic [2:0]  stat_a;
    logic [31:0] cyc_a, ins_a;

    phase_ctrl #(.RUN_ON_RESET(1), .WAIT_MAX(4), .CNT_WIDTH(32)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_run(run_a), .i_halt_req(hreq_a),
        .i_step(step_a), .i_inst_ld(ld_a), .i_inst_st(st_a),
        .i_mem_ready(rdy_a), .i_err_clr(clr_a),
        .o_phf(phf_a), .o_phe(phe_a), .o_phm(phm_a), .o_phw(phw_a),
        .o_mem_req(req_a), .o_mem_wen(wen_a), .o_halted(hlt_a),
        .o_bus_err(err_a), .o_clk_stat(stat_a), .o_cyc_cnt(cyc_a),
        .o_ins_cnt(ins_a)
    );

    // ---------------- instance B ----------------
    logic rst_b, run_b, hreq_b, step_b, ld_b, st_b, rdy_b, clr_b;
    logic phf_b, phe_b, phm_b, phw_b, req_b, wen_b, hlt_b, err_b;
    logic [2:0] stat_b;
    logic [3:0] cyc_b, ins_b;

    phase_ctrl #(.RUN_ON_RESET(0), .WAIT_MAX(15), .CNT_WIDTH(4)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_run(run_b), .i_halt_req(hreq_b),
        .i_step(step_b), .i_inst_ld(ld_b), .i_inst_st(st_b),
        .i_mem_ready(rdy_b), .i_err_clr(clr_b),
        .o_phf(phf_b), .o_phe(phe_b), .o_phm(phm_b), .o_phw(phw_b),
        .o_mem_req(req_b), .o_mem_wen(wen_b), .o_halted(hlt_b),
        .o_bus_err(err_b), .o_clk_stat(stat_b), .o_cyc_cnt(cyc_b),
        .o_ins_cnt(ins_b)
    );

    wire [7:0] o_a = {phf_a, phe_a, phm_a, phw_a, req_a, wen_a, hlt_a, err_a};
    wire [7:0] o_b = {phf_b, phe_b, phm_b, phw_b, req_b, wen_b, hlt_b, err_b};

    // Vector record: inputs for one cycle and the outputs expected in it.
    // exp_o bit order: {phf, phe, phm, phw, mem_req, mem_wen, halted, bus_err}
    typedef struct {
        logic        run, hreq, step, ld, st, rdy, clr;
        logic [7:0]  exp_o;
        logic [2:0]  exp_stat;
        logic [31:0] exp_cyc;
        logic [31:0] exp_ins;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic run, input logic hreq, input logic step,
                       input logic ld, input logic st, input logic rdy,
                       input logic clr, input logic [7:0] eo,
                       input logic [2:0] es, input int ec, input int ei);
        vec_t v;
        v.run = run; v.hreq = hreq; v.step = step; v.ld = ld; v.st = st;
        v.rdy = rdy; v.clr = clr; v.exp_o = eo; v.exp_stat = es;
        v.exp_cyc = 32'(ec); v.exp_ins = 32'(ei);
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; run_a = 1'b1; hreq_a = 1'b0; step_a = 1'b0;
        ld_a = 1'b0; st_a = 1'b0; rdy_a = 1'b1; clr_a = 1'b0;
        rst_b = 1'b1; run_b = 1'b0; hreq_b = 1'b0; step_b = 1'b0;
        ld_b = 1'b0; st_b = 1'b0; rdy_b = 1'b0; clr_b = 1'b0;

        // Basic run: three zero-wait instructions, 4 cycles each.
        for (int k = 0; k < 3; k++) begin
            add(1,0,0,0,0,1,0, 8'b1000_1000, 3'd1, 4*k,   k);
            add(1,0,0,0,0,1,0, 8'b0100_0000, 3'd2, 4*k+1, k);
            add(1,0,0,0,0,1,0, 8'b0010_0000, 3'd3, 4*k+2, k);
            add(1,0,0,0,0,1,0, 8'b0001_0000, 3'd4, 4*k+3, k);
        end
        // LD: 2 fetch waits, 3 MEM waits -> 9 cycles, mem_wen stays 0.
        add(1,0,0,1,0,0,0, 8'b0000_1000, 3'd1, 12, 3);
        add(1,0,0,1,0,0,0, 8'b0000_1000, 3'd1, 13, 3);
        add(1,0,0,1,0,1,0, 8'b1000_1000, 3'd1, 14, 3);
        add(1,0,0,1,0,0,0, 8'b0100_0000, 3'd2, 15, 3);
        add(1,0,0,1,0,0,0, 8'b0000_1000, 3'd3, 16, 3);
        add(1,0,0,1,0,0,0, 8'b0000_1000, 3'd3, 17, 3);
        add(1,0,0,1,0,0,0, 8'b0000_1000, 3'd3, 18, 3);
        add(1,0,0,1,0,1,0, 8'b0010_1000, 3'd3, 19, 3);
        add(1,0,0,1,0,0,0, 8'b0001_0000, 3'd4, 20, 3);
        // ST with no acknowledge: forced completion on the 5th MEM cycle.
        add(1,0,0,0,1,1,0, 8'b1000_1000, 3'd1, 21, 4);
        add(1,0,0,0,1,0,0, 8'b0100_0000, 3'd2, 22, 4);
        add(1,0,0,0,1,0,0, 8'b0000_1100, 3'd3, 23, 4);
        add(1,0,0,0,1,0,0, 8'b0000_1100, 3'd3, 24, 4);
        add(1,0,0,0,1,0,0, 8'b0000_1100, 3'd3, 25, 4);
        add(1,0,0,0,1,0,0, 8'b0000_1100, 3'd3, 26, 4);
        add(1,0,0,0,1,0,0, 8'b0010_1100, 3'd3, 27, 4);
        add(1,0,0,0,1,0,0, 8'b0001_0001, 3'd4, 28, 4);
        // halt_req raised in EXEC: instruction completes, then HALT.
        add(1,0,0,0,0,1,0, 8'b1000_1001, 3'd1, 29, 5);
        add(1,1,0,0,0,0,0, 8'b0100_0001, 3'd2, 30, 5);
        add(1,1,0,0,0,0,0, 8'b0010_0001, 3'd3, 31, 5);
        add(1,1,0,0,0,0,0, 8'b0001_0001, 3'd4, 32, 5);
        add(1,1,0,0,0,0,0, 8'b0000_0011, 3'd0, 33, 6);
        // err_clr pulse clears the sticky flag on the next cycle.
        add(1,1,0,0,0,0,1, 8'b0000_0011, 3'd0, 33, 6);
        add(1,1,0,0,0,0,0, 8'b0000_0010, 3'd0, 33, 6);
        // Step edge while halt_req=1: exactly one instruction; held step ignored.
        add(1,1,1,0,0,1,0, 8'b0000_0010, 3'd0, 33, 6);
        add(1,1,1,0,0,1,0, 8'b1000_1000, 3'd1, 33, 6);
        add(1,1,1,0,0,1,0, 8'b0100_0000, 3'd2, 34, 6);
        add(1,1,1,0,0,1,0, 8'b0010_0000, 3'd3, 35, 6);
        add(1,1,1,0,0,1,0, 8'b0001_0000, 3'd4, 36, 6);
        add(1,1,1,0,0,1,0, 8'b0000_0010, 3'd0, 37, 7);
        add(1,1,1,0,0,1,0, 8'b0000_0010, 3'd0, 37, 7);
        add(1,1,0,0,0,1,0, 8'b0000_0010, 3'd0, 37, 7);
        // Step-launched instruction returns to HALT even with run=1, halt_req=0.
        add(1,0,1,0,0,1,0, 8'b0000_0010, 3'd0, 37, 7);
        add(1,0,1,0,0,1,0, 8'b1000_1000, 3'd1, 37, 7);
        add(1,0,1,0,0,1,0, 8'b0100_0000, 3'd2, 38, 7);
        add(1,0,1,0,0,1,0, 8'b0010_0000, 3'd3, 39, 7);
        add(1,0,1,0,0,1,0, 8'b0001_0000, 3'd4, 40, 7);
        add(0,0,0,0,0,1,0, 8'b0000_0010, 3'd0, 41, 8);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            run_a = tbl[i].run; hreq_a = tbl[i].hreq; step_a = tbl[i].step;
            ld_a = tbl[i].ld; st_a = tbl[i].st; rdy_a = tbl[i].rdy; clr_a = tbl[i].clr;
            #1;
            chk($sformatf("A[%0d] outputs", i), {24'd0, o_a}, {24'd0, tbl[i].exp_o});
            chk($sformatf("A[%0d] clk_stat", i), {29'd0, stat_a}, {29'd0, tbl[i].exp_stat});
            chk($sformatf("A[%0d] cyc_cnt", i), cyc_a, tbl[i].exp_cyc);
            chk($sformatf("A[%0d] ins_cnt", i), ins_a, tbl[i].exp_ins);
            @(negedge clk);
        end

        // Instance B: reset state with RUN_ON_RESET=0.
        rst_b = 1'b0;
        #1;
        chk("B reset outputs", {24'd0, o_b}, 32'h0000_0002);
        chk("B reset stat", {29'd0, stat_b}, 32'd0);
        chk("B reset cyc", {28'd0, cyc_b}, 32'd0);
        chk("B reset ins", {28'd0, ins_b}, 32'd0);
        run_b = 1'b1; rdy_b = 1'b1;

        // 17 zero-wait instructions with 4-bit counters.
        for (int i = 0; i < 68; i++) begin
            @(negedge clk);
            if (i == 67) run_b = 1'b0;
            #1;
            chk($sformatf("B wrap stat %0d", i), {29'd0, stat_b}, 32'((i % 4) + 1));
        end
        @(negedge clk);
        #1;
        chk("B wrap halted", {24'd0, o_b}, 32'h0000_0002);
        chk("B wrap cyc", {28'd0, cyc_b}, 32'd4);
        chk("B wrap ins", {28'd0, ins_b}, 32'd1);

        // Reset during a MEM wait cycle of an LD.
        run_b = 1'b1; ld_b = 1'b1; rdy_b = 1'b1;
        @(negedge clk); #1;
        chk("B mid fetch", {24'd0, o_b}, 32'h0000_0088);
        @(negedge clk); rdy_b = 1'b0; #1;
        chk("B mid exec", {29'd0, stat_b}, 32'd2);
        @(negedge clk); #1;
        chk("B mid mem wait", {24'd0, o_b}, 32'h0000_0008);
        chk("B mid mem stat", {29'd0, stat_b}, 32'd3);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0; run_b = 1'b0;
        #1;
        chk("B post-reset outputs", {24'd0, o_b}, 32'h0000_0002);
        chk("B post-reset stat", {29'd0, stat_b}, 32'd0);
        chk("B post-reset cyc", {28'd0, cyc_b}, 32'd0);
        chk("B post-reset ins", {28'd0, ins_b}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
